// File: rtl/s2_logic_module.sv
// s2_logic_module: gated-select 4:1 mux feeding one D flop.
// Base storage cell; hold is done by feeding S2_out back to D0.
module s2_logic_module (
  input  logic CLK,
  input  logic CLR,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic A1,
  input  logic B1,
  input  logic A0,
  input  logic B0,
  output logic S2_out
);

  logic       s1;
  logic       s0;
  logic [1:0] sel;
  logic       m;

  assign s1  = A1 | B1;
  assign s0  = A0 & B0;
  assign sel = {s1, s0};

  // pick one data input; unselected inputs never reach m
  always_comb begin
    m = 1'b0;
    case (sel)
      2'd0:    m = D0;
      2'd1:    m = D1;
      2'd2:    m = D2;
      default: m = D3;
    endcase
  end

  // storage flop, clear overrides any select/data activity
  always_ff @(posedge CLK) begin
    if (CLR) S2_out <= 1'b0;
    else     S2_out <= m;
  end

endmodule

// File: tb/tb_s2_logic_module.sv
// tb_s2_logic_module: directed vectors for s2_logic_module.
// Covers clear, select map, gate logic, load-register hookup.
module tb_s2_logic_module;

  logic clk;
  logic clr;
  logic a1, b1, a0, b0;
  logic d0_r, d1_r, d2_r, d3_r;
  logic hook;
  logic q;
  logic d0, d3;

  int checks;
  int failures;

  assign d0 = hook ? q : d0_r;
  assign d3 = d3_r;

  s2_logic_module dut (
    .CLK   (clk),
    .CLR   (clr),
    .D0    (d0),
    .D1    (d1_r),
    .D2    (d2_r),
    .D3    (d3),
    .A1    (a1),
    .B1    (b1),
    .A0    (a0),
    .B0    (b0),
    .S2_out(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic got,
                     input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic ia1, input logic ib1,
                         input logic ia0, input logic ib0);
    a1 = ia1; b1 = ib1; a0 = ia0; b0 = ib0;
  endtask

  task automatic set_d(input logic [3:0] d);
    d0_r = d[0]; d1_r = d[1]; d2_r = d[2]; d3_r = d[3];
  endtask

  task automatic sel_n(input int s);
    case (s)
      0:       set_sel(0, 0, 0, 0);
      1:       set_sel(0, 0, 1, 1);
      2:       set_sel(1, 0, 0, 0);
      default: set_sel(0, 1, 1, 1);
    endcase
  endtask

  task automatic ld_reg(input logic ld, input logic d);
    a1 = ld; b1 = ld; a0 = ld; b0 = 1'b1;
    d1_r = 1'b0; d2_r = 1'b0; d3_r = d;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    hook     = 1'b0;
    clr      = 1'b1;
    set_d(4'b1111);
    set_sel(1, 1, 1, 1);
    #2;

    // clear with everything high
    step();
    chk("clr_first", q, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("clr_hold", q, 1'b0);
    end

    // select map, one-hot data rotated
    clr = 1'b0;
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 4; j++) begin
        sel_n(s);
        set_d(4'(1 << j));
        step();
        chk($sformatf("map_s%0d_d%0d", s, j), q, s == j);
      end
    end

    // gate logic: S0 = 0, S1 = 1 -> sel 2
    set_sel(0, 1, 1, 0);
    set_d(4'b0100);
    step();
    chk("gate_sel2", q, 1'b1);
    set_d(4'b1011);
    step();
    chk("gate_sel2_lo", q, 1'b0);
    d0_r = 1'bx; d1_r = 1'bx; d2_r = 1'b1; d3_r = 1'bx;
    step();
    chk("gate_x_block", q, 1'b1);

    // load-register hookup
    hook = 1'b1;
    ld_reg(1'b0, 1'b0);
    clr = 1'b1;
    step();
    chk("lr_clr", q, 1'b0);
    clr = 1'b0;
    ld_reg(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lr_hold0", q, 1'b0);
    end
    ld_reg(1'b1, 1'b1);
    step();
    chk("lr_load1", q, 1'b1);
    ld_reg(1'b0, 1'b0);
    step();
    chk("lr_hold1", q, 1'b1);
    step();
    chk("lr_hold1b", q, 1'b1);
    ld_reg(1'b1, 1'b0);
    step();
    chk("lr_load0", q, 1'b0);

    // clear priority over a load of 1
    ld_reg(1'b1, 1'b1);
    step();
    chk("pri_set", q, 1'b1);
    clr = 1'b1;
    step();
    chk("pri_clr", q, 1'b0);
    clr = 1'b0;
    step();
    chk("pri_release", q, 1'b1);

    // clear pulse between edges is ignored
    ld_reg(1'b0, 1'b0);
    clr = 1'b1;
    #3;
    chk("sync_mid", q, 1'b1);
    clr = 1'b0;
    step();
    chk("sync_pulse", q, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
